// File: rtl/usb_arb_pkg.sv
// Shared constants and types for the USB stream arbiter: the in-band escape
// bytes, the RX destination encoding and the RX escape parser state.
package usb_arb_pkg;

  localparam logic [7:0] ESC_BYTE     = 8'h1B;
  localparam logic [7:0] ESC_SEL_JTAG = 8'h4A;  // 'J'
  localparam logic [7:0] ESC_SEL_CFG  = 8'h43;  // 'C'

  localparam logic MODE_JTAG = 1'b0;
  localparam logic MODE_CFG  = 1'b1;

  typedef enum logic {
    S_DATA = 1'b0,
    S_ESC  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/usb_tx_rr_arbiter.sv
// Two-input round-robin merge of the JTAG and CFG response streams into a
// single one-entry output register towards the USB core.
module usb_tx_rr_arbiter
  import usb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n_i,
  input  logic [7:0] jtag_tx_data_i,
  input  logic       jtag_tx_valid_i,
  output logic       jtag_tx_ready_o,
  input  logic [7:0] cfg_tx_data_i,
  input  logic       cfg_tx_valid_i,
  output logic       cfg_tx_ready_o,
  output logic [7:0] host_tx_data_o,
  output logic       host_tx_valid_o,
  input  logic       host_tx_ready_i
);

  logic [7:0] tx_data_p1;
  logic       vld_p1;
  logic       last_grant;
  logic       can_load;
  logic       grant_jtag;
  logic       grant_cfg;

  // Grant the sole requester, or on a tie the one not served last.
  always_comb begin
    can_load   = !vld_p1 || host_tx_ready_i;
    grant_jtag = can_load && jtag_tx_valid_i &&
                 (!cfg_tx_valid_i || (last_grant == MODE_CFG));
    grant_cfg  = can_load && cfg_tx_valid_i &&
                 (!jtag_tx_valid_i || (last_grant == MODE_JTAG));
  end

  // Stage p1: output register and round-robin history.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_data_p1 <= 8'h00;
      vld_p1     <= 1'b0;
      last_grant <= MODE_CFG;
    end else if (grant_jtag) begin
      tx_data_p1 <= jtag_tx_data_i;
      vld_p1     <= 1'b1;
      last_grant <= MODE_JTAG;
    end else if (grant_cfg) begin
      tx_data_p1 <= cfg_tx_data_i;
      vld_p1     <= 1'b1;
      last_grant <= MODE_CFG;
    end else if (host_tx_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign jtag_tx_ready_o = grant_jtag;
  assign cfg_tx_ready_o  = grant_cfg;
  assign host_tx_data_o  = tx_data_p1;
  assign host_tx_valid_o = vld_p1;

endmodule

// File: rtl/usb_stream_arbiter.sv
// Shares one USB CDC byte stream between the JTAG bridge and the config
// loader. Host-to-device bytes are steered by an in-band escape parser into a
// one-entry holding register tagged with its destination; device-to-host
// responses are merged round-robin by usb_tx_rr_arbiter.
// Optional feature: define USB_ARB_TIMEOUT_EN to drop a held RX byte whose
// destination stalls for TIMEOUT_CYCLES consecutive cycles.
module usb_stream_arbiter
  import usb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n_i,
  input  logic [7:0] host_rx_data_i,
  input  logic       host_rx_valid_i,
  output logic       host_rx_ready_o,
  output logic [7:0] jtag_rx_data_o,
  output logic       jtag_rx_valid_o,
  input  logic       jtag_rx_ready_i,
  output logic [7:0] cfg_rx_data_o,
  output logic       cfg_rx_valid_o,
  input  logic       cfg_rx_ready_i,
  input  logic [7:0] jtag_tx_data_i,
  input  logic       jtag_tx_valid_i,
  output logic       jtag_tx_ready_o,
  input  logic [7:0] cfg_tx_data_i,
  input  logic       cfg_tx_valid_i,
  output logic       cfg_tx_ready_o,
  output logic [7:0] host_tx_data_o,
  output logic       host_tx_valid_o,
  input  logic       host_tx_ready_i,
  output logic       mode_o,
  output logic       esc_err_o,
  output logic       rx_drop_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("usb_stream_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  rx_state_e  state, state_n;
  logic       mode, mode_n;
  logic       err_n;
  logic       load;
  logic [7:0] rx_data_p1;
  logic       rx_dest_p1;
  logic       vld_p1;
  logic       dest_ready;
  logic       rx_accept;
  logic       drain;
  logic       drop_now;
  logic       err_p1;

  // Handshake: escape and mode bytes also wait for a free slot so that
  // control bytes never overtake a data byte still in the holding register.
  always_comb begin
    dest_ready      = (rx_dest_p1 == MODE_CFG) ? cfg_rx_ready_i : jtag_rx_ready_i;
    host_rx_ready_o = !vld_p1 || dest_ready;
    rx_accept       = host_rx_valid_i && host_rx_ready_o;
    drain           = vld_p1 && dest_ready;
  end

  // Escape parser: decide per accepted byte whether to forward, switch mode
  // or flag a bad escape.
  always_comb begin
    state_n = state;
    mode_n  = mode;
    load    = 1'b0;
    err_n   = 1'b0;
    if (rx_accept) begin
      case (state)
        S_DATA: begin
          if (host_rx_data_i == ESC_BYTE) state_n = S_ESC;
          else                            load    = 1'b1;
        end
        S_ESC: begin
          state_n = S_DATA;
          if (host_rx_data_i == ESC_SEL_JTAG)     mode_n = MODE_JTAG;
          else if (host_rx_data_i == ESC_SEL_CFG) mode_n = MODE_CFG;
          else if (host_rx_data_i == ESC_BYTE)    load   = 1'b1;
          else                                    err_n  = 1'b1;
        end
        default: state_n = S_DATA;
      endcase
    end
  end

  // Parser state, current mode and the registered error pulse.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= S_DATA;
      mode   <= MODE_JTAG;
      err_p1 <= 1'b0;
    end else begin
      state  <= state_n;
      mode   <= mode_n;
      err_p1 <= err_n;
    end
  end

  // Stage p1: RX holding register; the tag is frozen at load so a later mode
  // switch cannot redirect a byte already waiting.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_data_p1 <= 8'h00;
      rx_dest_p1 <= MODE_JTAG;
      vld_p1     <= 1'b0;
    end else if (load) begin
      rx_data_p1 <= host_rx_data_i;
      rx_dest_p1 <= mode;
      vld_p1     <= 1'b1;
    end else if (drain || drop_now) begin
      vld_p1 <= 1'b0;
    end
  end

`ifdef USB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] stall_cnt;
  logic             stall;
  logic             drop_p1;

  // Stall detection: the held byte's destination refuses it this cycle.
  always_comb begin
    stall    = vld_p1 && !dest_ready;
    drop_now = stall && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Consecutive-stall counter and the registered drop pulse.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt <= '0;
      drop_p1   <= 1'b0;
    end else begin
      drop_p1 <= drop_now;
      if (!stall || drop_now) stall_cnt <= '0;
      else                    stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign rx_drop_o = drop_p1;
`else
  assign drop_now  = 1'b0;
  assign rx_drop_o = 1'b0;
`endif

  assign jtag_rx_data_o  = rx_data_p1;
  assign cfg_rx_data_o   = rx_data_p1;
  assign jtag_rx_valid_o = vld_p1 && (rx_dest_p1 == MODE_JTAG);
  assign cfg_rx_valid_o  = vld_p1 && (rx_dest_p1 == MODE_CFG);
  assign mode_o          = mode;
  assign esc_err_o       = err_p1;

  usb_tx_rr_arbiter u_tx_arb (
    .clk             (clk),
    .rst_n_i         (rst_n_i),
    .jtag_tx_data_i  (jtag_tx_data_i),
    .jtag_tx_valid_i (jtag_tx_valid_i),
    .jtag_tx_ready_o (jtag_tx_ready_o),
    .cfg_tx_data_i   (cfg_tx_data_i),
    .cfg_tx_valid_i  (cfg_tx_valid_i),
    .cfg_tx_ready_o  (cfg_tx_ready_o),
    .host_tx_data_o  (host_tx_data_o),
    .host_tx_valid_o (host_tx_valid_o),
    .host_tx_ready_i (host_tx_ready_i)
  );

endmodule

// File: tb/tb_usb_stream_arbiter.sv
// Directed bench for usb_stream_arbiter: an RX vector table plus hand-written
// sequences for held-byte tagging, TX round-robin, timeout and mid-run reset.
module tb_usb_stream_arbiter;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic [7:0] host_rx_data_i;
  logic       host_rx_valid_i;
  logic       host_rx_ready_o;
  logic [7:0] jtag_rx_data_o;
  logic       jtag_rx_valid_o;
  logic       jtag_rx_ready_i;
  logic [7:0] cfg_rx_data_o;
  logic       cfg_rx_valid_o;
  logic       cfg_rx_ready_i;
  logic [7:0] jtag_tx_data_i;
  logic       jtag_tx_valid_i;
  logic       jtag_tx_ready_o;
  logic [7:0] cfg_tx_data_i;
  logic       cfg_tx_valid_i;
  logic       cfg_tx_ready_o;
  logic [7:0] host_tx_data_o;
  logic       host_tx_valid_o;
  logic       host_tx_ready_i;
  logic       mode_o;
  logic       esc_err_o;
  logic       rx_drop_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  usb_stream_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rst_n_i         (rst_n_i),
    .host_rx_data_i  (host_rx_data_i),
    .host_rx_valid_i (host_rx_valid_i),
    .host_rx_ready_o (host_rx_ready_o),
    .jtag_rx_data_o  (jtag_rx_data_o),
    .jtag_rx_valid_o (jtag_rx_valid_o),
    .jtag_rx_ready_i (jtag_rx_ready_i),
    .cfg_rx_data_o   (cfg_rx_data_o),
    .cfg_rx_valid_o  (cfg_rx_valid_o),
    .cfg_rx_ready_i  (cfg_rx_ready_i),
    .jtag_tx_data_i  (jtag_tx_data_i),
    .jtag_tx_valid_i (jtag_tx_valid_i),
    .jtag_tx_ready_o (jtag_tx_ready_o),
    .cfg_tx_data_i   (cfg_tx_data_i),
    .cfg_tx_valid_i  (cfg_tx_valid_i),
    .cfg_tx_ready_o  (cfg_tx_ready_o),
    .host_tx_data_o  (host_tx_data_o),
    .host_tx_valid_o (host_tx_valid_o),
    .host_tx_ready_i (host_tx_ready_i),
    .mode_o          (mode_o),
    .esc_err_o       (esc_err_o),
    .rx_drop_o       (rx_drop_o)
  );

  // One RX vector: inputs applied for a cycle, outputs expected mid-cycle.
  typedef struct {
    logic       rv;
    logic [7:0] rd;
    logic       jr;
    logic       cr;
    logic       ejv;
    logic       ecv;
    logic [7:0] ed;
    logic       em;
    logic       erdy;
    logic       eerr;
  } vec_t;

  vec_t tbl [12];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk1({tag, " host_rx_ready"}, host_rx_ready_o, 1'b1);
    chk1({tag, " jtag_rx_valid"}, jtag_rx_valid_o, 1'b0);
    chk1({tag, " cfg_rx_valid"}, cfg_rx_valid_o, 1'b0);
    chk1({tag, " host_tx_valid"}, host_tx_valid_o, 1'b0);
    chk8({tag, " jtag_rx_data"}, jtag_rx_data_o, 8'h00);
    chk8({tag, " cfg_rx_data"}, cfg_rx_data_o, 8'h00);
    chk8({tag, " host_tx_data"}, host_tx_data_o, 8'h00);
    chk1({tag, " mode"}, mode_o, 1'b0);
    chk1({tag, " esc_err"}, esc_err_o, 1'b0);
    chk1({tag, " rx_drop"}, rx_drop_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall;
    logic seen_drop;

    // B, R to JTAG; ESC C AA to CFG; ESC ESC literal; ESC x error.
    tbl[0]  = '{1'b1, 8'h42, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 8'h52, 1'b1, 1'b1, 1'b1, 1'b0, 8'h42, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h52, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 8'h1B, 1'b1, 1'b1, 1'b0, 1'b0, 8'h52, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 8'h43, 1'b1, 1'b1, 1'b0, 1'b0, 8'h52, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 8'h52, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'h1B, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 8'h1B, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 8'h1B, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1B, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 8'h78, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1B, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1B, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1B, 1'b1, 1'b1, 1'b0};

    rst_n_i         = 1'b0;
    host_rx_data_i  = 8'h00;
    host_rx_valid_i = 1'b0;
    jtag_rx_ready_i = 1'b1;
    cfg_rx_ready_i  = 1'b1;
    jtag_tx_data_i  = 8'h00;
    jtag_tx_valid_i = 1'b0;
    cfg_tx_data_i   = 8'h00;
    cfg_tx_valid_i  = 1'b0;
    host_tx_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    chk1("reset jtag_tx_ready", jtag_tx_ready_o, 1'b0);
    chk1("reset cfg_tx_ready", cfg_tx_ready_o, 1'b0);
    drive_edge();
    rst_n_i = 1'b1;

    // RX vector table.
    for (int i = 0; i < 12; i++) begin
      drive_edge();
      host_rx_valid_i = tbl[i].rv;
      host_rx_data_i  = tbl[i].rd;
      jtag_rx_ready_i = tbl[i].jr;
      cfg_rx_ready_i  = tbl[i].cr;
      @(negedge clk);
      chk1($sformatf("vec%0d jtag_rx_valid", i), jtag_rx_valid_o, tbl[i].ejv);
      chk1($sformatf("vec%0d cfg_rx_valid", i), cfg_rx_valid_o, tbl[i].ecv);
      if (tbl[i].ejv || tbl[i].ecv)
        chk8($sformatf("vec%0d rx_data", i), cfg_rx_data_o, tbl[i].ed);
      chk8($sformatf("vec%0d jtag_rx_data", i), jtag_rx_data_o, tbl[i].ed);
      chk1($sformatf("vec%0d mode", i), mode_o, tbl[i].em);
      chk1($sformatf("vec%0d host_rx_ready", i), host_rx_ready_o, tbl[i].erdy);
      chk1($sformatf("vec%0d esc_err", i), esc_err_o, tbl[i].eerr);
    end

    // Held byte keeps its JTAG tag across a later switch to CFG.
    drive_edge();
    host_rx_valid_i = 1'b1;
    host_rx_data_i  = 8'h1B;
    drive_edge();
    host_rx_data_i  = 8'h4A;
    drive_edge();
    host_rx_data_i  = 8'h31;
    jtag_rx_ready_i = 1'b0;
    drive_edge();
    host_rx_data_i  = 8'h1B;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("held jtag_rx_valid", jtag_rx_valid_o, 1'b1);
      chk8("held jtag_rx_data", jtag_rx_data_o, 8'h31);
      chk1("held host_rx_ready", host_rx_ready_o, 1'b0);
      chk1("held mode", mode_o, 1'b0);
      drive_edge();
    end
    jtag_rx_ready_i = 1'b1;
    @(negedge clk);
    chk1("release host_rx_ready", host_rx_ready_o, 1'b1);
    chk1("release cfg_rx_valid", cfg_rx_valid_o, 1'b0);
    drive_edge();
    host_rx_data_i = 8'h43;
    @(negedge clk);
    chk1("after drain jtag_rx_valid", jtag_rx_valid_o, 1'b0);
    chk1("after drain mode", mode_o, 1'b0);
    drive_edge();
    host_rx_valid_i = 1'b0;
    @(negedge clk);
    chk1("switch mode", mode_o, 1'b1);
    chk1("switch jtag_rx_valid", jtag_rx_valid_o, 1'b0);
    chk1("switch cfg_rx_valid", cfg_rx_valid_o, 1'b0);

    // TX round-robin with both requesters held valid.
    drive_edge();
    jtag_tx_valid_i = 1'b1;
    jtag_tx_data_i  = 8'hA1;
    cfg_tx_valid_i  = 1'b1;
    cfg_tx_data_i   = 8'hC1;
    host_tx_ready_i = 1'b1;
    @(negedge clk);
    chk1("tie0 jtag_tx_ready", jtag_tx_ready_o, 1'b1);
    chk1("tie0 cfg_tx_ready", cfg_tx_ready_o, 1'b0);
    chk1("tie0 host_tx_valid", host_tx_valid_o, 1'b0);
    drive_edge();
    @(negedge clk);
    chk1("tie1 host_tx_valid", host_tx_valid_o, 1'b1);
    chk8("tie1 host_tx_data", host_tx_data_o, 8'hA1);
    chk1("tie1 cfg_tx_ready", cfg_tx_ready_o, 1'b1);
    chk1("tie1 jtag_tx_ready", jtag_tx_ready_o, 1'b0);
    drive_edge();
    @(negedge clk);
    chk8("tie2 host_tx_data", host_tx_data_o, 8'hC1);
    chk1("tie2 jtag_tx_ready", jtag_tx_ready_o, 1'b1);
    drive_edge();
    @(negedge clk);
    chk8("tie3 host_tx_data", host_tx_data_o, 8'hA1);
    drive_edge();
    jtag_tx_valid_i = 1'b0;
    cfg_tx_valid_i  = 1'b0;
    @(negedge clk);
    chk1("tie4 host_tx_valid", host_tx_valid_o, 1'b1);
    chk8("tie4 host_tx_data", host_tx_data_o, 8'hC1);
    drive_edge();
    @(negedge clk);
    chk1("tie5 host_tx_valid", host_tx_valid_o, 1'b0);

    // TX backpressure from the USB core.
    drive_edge();
    host_tx_ready_i = 1'b0;
    jtag_tx_valid_i = 1'b1;
    jtag_tx_data_i  = 8'h5A;
    @(negedge clk);
    chk1("bp load jtag_tx_ready", jtag_tx_ready_o, 1'b1);
    drive_edge();
    jtag_tx_data_i = 8'h6B;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk1("bp hold host_tx_valid", host_tx_valid_o, 1'b1);
      chk8("bp hold host_tx_data", host_tx_data_o, 8'h5A);
      chk1("bp hold jtag_tx_ready", jtag_tx_ready_o, 1'b0);
      drive_edge();
    end
    host_tx_ready_i = 1'b1;
    @(negedge clk);
    chk1("bp release jtag_tx_ready", jtag_tx_ready_o, 1'b1);
    drive_edge();
    jtag_tx_valid_i = 1'b0;
    @(negedge clk);
    chk8("bp next host_tx_data", host_tx_data_o, 8'h6B);
    drive_edge();
    @(negedge clk);
    chk1("bp empty host_tx_valid", host_tx_valid_o, 1'b0);

    // Stalled CFG destination (mode is CFG here).
    drive_edge();
    host_rx_valid_i = 1'b1;
    host_rx_data_i  = 8'h55;
    cfg_rx_ready_i  = 1'b0;
    drive_edge();
    host_rx_valid_i = 1'b0;
    stall     = 0;
    seen_drop = 1'b0;
`ifdef USB_ARB_TIMEOUT_EN
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!cfg_rx_valid_o) break;
      if (rx_drop_o) seen_drop = 1'b1;
      stall++;
    end
    chk8("timeout stall cycles", 8'(stall), 8'd8);
    chk1("timeout early drop", seen_drop, 1'b0);
    chk1("timeout rx_drop pulse", rx_drop_o, 1'b1);
    chk1("timeout host_rx_ready", host_rx_ready_o, 1'b1);
    @(negedge clk);
    chk1("timeout rx_drop end", rx_drop_o, 1'b0);
    cfg_rx_ready_i = 1'b1;
`else
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cfg_rx_valid_o) stall++;
      if (rx_drop_o) seen_drop = 1'b1;
    end
    chk8("no-timeout stall cycles", 8'(stall), 8'd20);
    chk1("no-timeout rx_drop", seen_drop, 1'b0);
    chk1("no-timeout host_rx_ready", host_rx_ready_o, 1'b0);
    drive_edge();
    cfg_rx_ready_i = 1'b1;
    @(negedge clk);
    chk1("no-timeout release ready", host_rx_ready_o, 1'b1);
    drive_edge();
    @(negedge clk);
    chk1("no-timeout drained", cfg_rx_valid_o, 1'b0);
`endif

    // Reset in the middle of traffic in both directions.
    drive_edge();
    host_rx_valid_i = 1'b1;
    host_rx_data_i  = 8'h66;
    cfg_rx_ready_i  = 1'b0;
    host_tx_ready_i = 1'b0;
    jtag_tx_valid_i = 1'b1;
    jtag_tx_data_i  = 8'h77;
    drive_edge();
    host_rx_valid_i = 1'b0;
    jtag_tx_valid_i = 1'b0;
    @(negedge clk);
    chk1("pre-reset cfg_rx_valid", cfg_rx_valid_o, 1'b1);
    chk1("pre-reset host_tx_valid", host_tx_valid_o, 1'b1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_reset_state("midreset");
    drive_edge();
    rst_n_i         = 1'b1;
    cfg_rx_ready_i  = 1'b1;
    host_tx_ready_i = 1'b1;
    jtag_tx_valid_i = 1'b1;
    cfg_tx_valid_i  = 1'b1;
    @(negedge clk);
    chk1("post-reset tie jtag_tx_ready", jtag_tx_ready_o, 1'b1);
    chk1("post-reset tie cfg_tx_ready", cfg_tx_ready_o, 1'b0);
    drive_edge();
    jtag_tx_valid_i = 1'b0;
    cfg_tx_valid_i  = 1'b0;
    @(negedge clk);
    chk8("post-reset host_tx_data", host_tx_data_o, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/usb_stream_arbiter.md
# usb_stream_arbiter

Shares the single USB CDC byte stream between the JTAG bridge and the configuration bitstream loader. On the host-to-device side, an in-band escape parser selects which consumer receives each byte. On the device-to-host side, a round-robin arbiter merges the two response streams into one. It sits between the USB core and both consumers.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: consecutive stall cycles before a held RX byte is dropped. Used only with USB_ARB_TIMEOUT_EN.

Ports:
- Reset `rst_n_i` is asynchronous, active-low; clock is `clk`.
- clk  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- host_rx_data_i  in  8  byte from USB core
- host_rx_valid_i  in  1  host byte valid
- host_rx_ready_o  out  1  block accepts host byte
- jtag_rx_data_o  out  8  byte to JTAG bridge
- jtag_rx_valid_o  out  1  JTAG byte valid
- jtag_rx_ready_i  in  1  JTAG bridge accepts
- cfg_rx_data_o  out  8  byte to config loader
- cfg_rx_valid_o  out  1  config byte valid
- cfg_rx_ready_i  in  1  config loader accepts
- jtag_tx_data_i  in  8  response byte from JTAG bridge
- jtag_tx_valid_i  in  1  JTAG response valid
- jtag_tx_ready_o  out  1  JTAG response accepted
- cfg_tx_data_i  in  8  response byte from config loader
- cfg_tx_valid_i  in  1  config response valid
- cfg_tx_ready_o  out  1  config response accepted
- host_tx_data_o  out  8  byte to USB core
- host_tx_valid_o  out  1  host byte valid
- host_tx_ready_i  in  1  USB core accepts
- mode_o  out  1  current RX destination: 0 = JTAG, 1 = CFG
- esc_err_o  out  1  one-cycle pulse on an invalid escape sequence
- rx_drop_o  out  1  one-cycle pulse when a held RX byte is dropped on timeout

## Operation
- All handshakes: a transfer occurs on a clk edge where valid && ready. Valid, once asserted, holds its data until the transfer.
- RX escape parser has two states, S_DATA and S_ESC. Escape byte ESC = 8'h1B.
  - S_DATA, byte == ESC: consume the byte, do not forward it, go to S_ESC.
  - S_DATA, any other byte: load it into the RX holding register, tagged with the current mode.
  - S_ESC, 'J' (8'h4A): mode := 0, go to S_DATA. 'C' (8'h43): mode := 1, go to S_DATA. Neither byte is forwarded.
  - S_ESC, ESC: forward a literal 8'h1B with the current mode tag, go to S_DATA.
  - S_ESC, any other byte: consume and discard, pulse esc_err_o, go to S_DATA; mode unchanged.
- RX holding register is one entry: data[7:0], dest tag, full flag.
  - The output valid for the tag's destination = full. The other destination's valid = 0.
  - Both jtag_rx_data_o and cfg_rx_data_o carry the holding data.
- The tag is latched at load. A mode change after load does not redirect the held byte.
- host_rx_ready_o = !full || (full && ready of tagged destination). Escape and mode bytes need a free slot by the same rule, so ordering is preserved.
- TX arbiter: one-entry output register driving host_tx_*.
  - The register loads when it is empty or is being accepted this cycle.
  - Winner: the only valid requester; if both are valid, the one not granted last.
  - The winner's tx_ready_o is asserted in the load cycle; the other requester's is 0.
  - last_grant updates on every grant.

## Timing
- Reset values: all valid outputs 0; host_rx_ready_o 1; jtag_tx_ready_o and cfg_tx_ready_o 0; data outputs 8'h00; mode_o 0; esc_err_o and rx_drop_o 0; parser in S_DATA; last_grant = CFG, so JTAG wins the first tie.
- RX latency: host byte accepted at edge N gives destination valid after edge N; sustained throughput is 1 byte/cycle.
- TX latency: a requester byte accepted at edge N gives host_tx_valid_o after edge N; 1 byte/cycle with host_tx_ready_i held high.
- Two simultaneous TX requesters held valid alternate on every accepted byte.
- Reset asserted mid-operation clears held bytes in both directions, returns mode to JTAG and the parser to S_DATA; no pulse outputs fire.

## Configuration
- USB_ARB_TIMEOUT_EN defined:
  - A counter sized to hold TIMEOUT_CYCLES increments while the RX register is full and its destination is not ready; it clears on any transfer or when the register is empty.
  - When the counter reaches TIMEOUT_CYCLES-1 and the destination is still not ready, the held byte is discarded (full := 0) and rx_drop_o pulses for one cycle.
- USB_ARB_TIMEOUT_EN undefined: there is no counter, a held byte waits indefinitely, and rx_drop_o is tied to 0.

## Structure
- Package usb_arb_pkg:
  - ESC_BYTE, ESC_SEL_JTAG, ESC_SEL_CFG constants.
  - MODE_JTAG/MODE_CFG constants.
  - Parser state typedef (S_DATA, S_ESC).
- Sub-module usb_tx_rr_arbiter contains the two-input round-robin TX arbiter and its output register. The RX parser and holding register stay in the top module.

## Test plan
- After reset, send 'B','R' with jtag_rx_ready_i=1 -> two bytes 8'h42, 8'h52 on jtag_rx_*, with cfg_rx_valid_o=0 throughout.
- Send 8'h1B,'C',8'hAA -> mode_o=1 after the 'C', and 8'hAA on cfg_rx_*; no JTAG valid.
- In CFG mode send 8'h1B,8'h1B -> single 8'h1B on cfg_rx_*. Then send 8'h1B,'x' -> esc_err_o pulses once, nothing forwarded, mode_o stays 1.
- Hold jtag_rx_ready_i=0 with byte 8'h31 held, then send 8'h1B,'C' -> the 8'h31 still delivers to JTAG when ready rises; mode_o=1 afterwards.
- jtag_tx_valid_i and cfg_tx_valid_i both held high with host_tx_ready_i=1 -> host_tx_data_o alternates JTAG, CFG, JTAG, starting with JTAG.
- With USB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, hold the held byte's destination not-ready -> rx_drop_o pulses after 8 stall cycles and host_rx_ready_o returns to 1.
